instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Program-side initiator for the simple processor's control unit: holds a small instruction store, presents one 16-bit instruction at a time, and drives Run. It waits for the processor's Done pulse before advancing. It replaces hand-driven Run/instruction stimulus at the top level, so that loaded programs execute back-to-back. A watchdog flags a processor that never returns Done.

Parameters:
DEPTH, 32, number of 16-bit instruction words in the store
AW, 5, address width; must equal clog2(DEPTH)
TIMEOUT, 15, maximum cycles in EXEC without Done before abort

Ports:
clock  input  1  single clock; all state updates on posedge
Rest  input  1  synchronous, active-high reset
prog_we  input  1  store write enable; honoured only in IDLE
prog_addr  input  AW  store write address
prog_data  input  16  store write data
start  input  1  begin execution; sampled in IDLE only
len  input  AW+1  number of words to run (1..DEPTH); sampled with start
Done  input  1  one-cycle completion pulse from the processor control unit
instruction  output  16  instruction word presented to the processor
Run  output  1  processor run enable
busy  output  1  high in every state except IDLE
pc  output  AW  index of the current word
issued_cnt  output  AW+1  instructions completed (Done received) this run
finished  output  1  one-cycle pulse on run completion
halted  output  1  sticky: the run ended on a HALT word
timeout_err  output  1  sticky: the run aborted by the watchdog

Behaviour:
- Reset (Rest=1 at posedge), from any state, including mid-EXEC:
  - state=IDLE.
  - instruction=0, Run=0, busy=0, pc=0, issued_cnt=0, finished=0, halted=0, timeout_err=0, wd counter=0.
  - Store contents are not cleared.
- Store: synchronous write when prog_we=1 in IDLE; writes in any other state are dropped. Read is synchronous, one cycle.
- States: IDLE, FETCH, CHECK, EXEC, FINISH.
- IDLE:
  - Run=0.
  - start=1 with len in 1..DEPTH: latch len, clear pc, issued_cnt, halted and timeout_err, then go to FETCH.
  - start with len=0 or len>DEPTH: go directly to FINISH with no issue.
  - start and prog_we in the same cycle: the write is performed and start is honoured.
- FETCH: read mem[pc]; Run=0; go to CHECK.
- CHECK: register the read word onto instruction.
  - Opcode bits [15:13]=3'b111 (HALT): set halted=1 and go to FINISH; the word is never issued.
  - Otherwise go to EXEC.
- EXEC:
  - Run=1; instruction held stable; wd counter increments every cycle.
  - Done=1: issued_cnt+1 and wd cleared. If pc+1==len, go to FINISH. Otherwise pc+1 and go to FETCH.
  - Run drops to 0 for the FETCH and CHECK cycles; the processor holds at T0 while Run=0.
  - wd reaching TIMEOUT with no Done: set timeout_err=1, Run=0 the next cycle, go to FINISH.
  - Done arriving in the same cycle as the timeout: Done wins and the instruction is counted.
- FINISH: finished=1 for exactly one cycle; Run=0; return to IDLE. pc and issued_cnt hold their final values until the next start.
- Done outside EXEC is ignored.
- Per-instruction latency:
  - Instruction issue: 2 cycles after entering FETCH.
  - Processor execution: 2 cycles (mv/mvt) or 4 cycles (add/sub) after Run rises.
  - Return to FETCH: on the Done cycle.
- pc never wraps: it is bounded by len ≤ DEPTH.
- issued_cnt saturates at DEPTH.

Test Plan:
1. Load mem[0..2]={16'h1205, 16'h0401, 16'h4003}, len=3, pulse start; model Done after 2, 2 and 4 Run cycles → three instructions presented in order, issued_cnt=3, finished pulses once, halted=0, timeout_err=0, pc=2.
2. mem[1]=16'hE000 (HALT), len=4 → only word 0 issued; halted=1, issued_cnt=1, finished pulse, and Run is never high with 16'hE000 on instruction.
3. Done held low in EXEC → Run high for exactly 15 cycles, then timeout_err=1, finished pulse, back in IDLE with issued_cnt=0.
4. Assert Rest during EXEC of word 1 → next cycle Run=0, pc=0, busy=0; the store still holds the program, and a new start reruns it from word 0.
5. start with len=0, and separately len=33 → finished pulses the next cycle, Run never rises, issued_cnt=0.
6. prog_we during EXEC to address 2 → store unchanged; word 2 executes its original value.

Source files
------------

// File: rtl/instr_sequencer.sv
// Purpose: steps a small instruction store through the processor control unit, one word per Run/Done handshake.
// Latency: a word reaches instruction/Run 2 cycles after FETCH; the next FETCH starts on the cycle after Done.
// Backpressure: Run stays high until Done arrives; a watchdog aborts the run after TIMEOUT cycles without Done.
//
// Ports:
//   clock, Rest                        - clock and synchronous active-high reset
//   prog_we, prog_addr, prog_data      - store write port, only honoured while idle
//   start, len                         - launch a run of len words (1..DEPTH) from word 0
//   Done                               - one-cycle completion pulse from the processor
//   instruction, Run                   - word presented to the processor and its run enable
//   busy, pc, issued_cnt               - activity flag, current word index, words completed
//   finished, halted, timeout_err      - end-of-run pulse, HALT-terminated flag, watchdog-abort flag
module instr_sequencer #(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          Rest,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          Done,
  output logic [15:0]   instruction,
  output logic          Run,
  output logic          busy,
  output logic [AW-1:0] pc,
  output logic [AW:0]   issued_cnt,
  output logic          finished,
  output logic          halted,
  output logic          timeout_err
);

  localparam int             WDW     = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]    DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CHECK, S_EXEC, S_FINISH} state_t;

  state_t        state, state_nxt;
  logic [15:0]   mem [DEPTH];
  logic [15:0]   rd_word;
  logic [AW:0]   len_q;
  logic [WDW-1:0] wd;
  logic          len_ok;
  logic          is_halt;
  logic          last_word;
  logic          wd_expired;

  assign len_ok     = (len != '0) && (len <= DEPTH_W);
  assign is_halt    = (rd_word[15:13] == 3'b111);
  assign last_word  = (({1'b0, pc} + {{AW{1'b0}}, 1'b1}) == len_q);
  // wd counts completed EXEC cycles, so the last permitted cycle sees TIMEOUT-1
  assign wd_expired = (wd == WD_LAST);

  // Store: no reset, so a loaded program survives Rest.
  always_ff @(posedge clock) begin
    if (prog_we && (state == S_IDLE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clock) begin
    if (Rest) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    Run       = 1'b0;
    busy      = 1'b1;
    finished  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = len_ok ? S_FETCH : S_FINISH;
        end
      end
      S_FETCH: state_nxt = S_CHECK;
      S_CHECK: state_nxt = is_halt ? S_FINISH : S_EXEC;
      S_EXEC: begin
        Run = 1'b1;
        // Done takes priority over a simultaneous watchdog expiry
        if (Done) begin
          state_nxt = last_word ? S_FINISH : S_FETCH;
        end else if (wd_expired) begin
          state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        finished  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Rest) begin
      instruction <= '0;
      pc          <= '0;
      issued_cnt  <= '0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
      wd          <= '0;
      len_q       <= '0;
      rd_word     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Any start (valid or not) opens a new run, so the result fields restart.
          if (start) begin
            pc          <= '0;
            issued_cnt  <= '0;
            halted      <= 1'b0;
            timeout_err <= 1'b0;
            wd          <= '0;
            if (len_ok) begin
              len_q <= len;
            end
          end
        end
        S_FETCH: rd_word <= mem[pc];
        S_CHECK: begin
          instruction <= rd_word;
          if (is_halt) begin
            halted <= 1'b1;
          end
        end
        S_EXEC: begin
          if (Done) begin
            wd <= '0;
            if (issued_cnt != DEPTH_W) begin
              issued_cnt <= issued_cnt + (AW+1)'(1);
            end
            if (!last_word) begin
              pc <= pc + AW'(1);
            end
          end else if (wd_expired) begin
            wd          <= '0;
            timeout_err <= 1'b1;
          end else begin
            wd <= wd + WDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a processor stand-in answers Run with Done after an opcode-dependent
// number of cycles, and a run-level model expands each start into the expected per-cycle outputs
// (two fetch cycles, N run cycles per word, one finish cycle) which are compared every cycle.
module tb_instr_sequencer;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int TO    = 15;

  logic          clock = 1'b0;
  logic          Rest;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          start;
  logic [AW:0]   len;
  logic          Done;
  logic [15:0]   instruction;
  logic          Run;
  logic          busy;
  logic [AW-1:0] pc;
  logic [AW:0]   issued_cnt;
  logic          finished;
  logic          halted;
  logic          timeout_err;

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TO)) dut (
    .clock(clock), .Rest(Rest), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .len(len), .Done(Done),
    .instruction(instruction), .Run(Run), .busy(busy), .pc(pc),
    .issued_cnt(issued_cnt), .finished(finished), .halted(halted),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0]   instr;
    logic          run;
    logic          busy;
    logic [AW-1:0] pc;
    logic [AW:0]   cnt;
    logic          fin;
    logic          halted;
    logic          terr;
  } obs_t;

  logic [15:0] mem_m [DEPTH];
  obs_t        exp_q[$];
  obs_t        idle_v = '0;
  obs_t        ce, ca;
  bit          cur_busy = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  int          run_hi = 0;
  int          fin_cnt = 0;
  bit          halt_issued = 1'b0;
  int          lat_override = 0;
  bit          stray_done = 1'b0;

  // Processor response time in Run cycles: add/sub take 4, everything else 2.
  function automatic int proc_lat(input logic [15:0] w);
    if (lat_override > 0) return lat_override;
    return (w[15:13] inside {3'b010, 3'b011}) ? 4 : 2;
  endfunction

  // Expected output trace for a run launched at the coming edge.
  task automatic build_run(input int n);
    obs_t e;
    int   lat;
    int   ex;
    e        = idle_v;
    e.busy   = 1'b1;
    e.run    = 1'b0;
    e.fin    = 1'b0;
    e.pc     = '0;
    e.cnt    = '0;
    e.halted = 1'b0;
    e.terr   = 1'b0;
    if (n >= 1 && n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        e.pc  = AW'(i);
        e.run = 1'b0;
        exp_q.push_back(e);
        exp_q.push_back(e);
        e.instr = mem_m[i];
        if (mem_m[i][15:13] == 3'b111) begin
          e.halted = 1'b1;
          break;
        end
        lat   = proc_lat(mem_m[i]);
        ex    = (lat > TO) ? TO : lat;
        e.run = 1'b1;
        for (int k = 0; k < ex; k++) exp_q.push_back(e);
        e.run = 1'b0;
        if (lat > TO) begin
          e.terr = 1'b1;
          break;
        end
        if (e.cnt < DEPTH) e.cnt = e.cnt + 1'b1;
        if (i == n - 1) break;
      end
    end
    e.run = 1'b0;
    e.fin = 1'b1;
    exp_q.push_back(e);
    e.busy = 1'b0;
    e.fin  = 1'b0;
    idle_v = e;
  endtask

  // Processor stand-in: pulses Done on the Nth consecutive Run cycle.
  initial begin
    int rcnt;
    rcnt = 0;
    Done = 1'b0;
    forever begin
      @(negedge clock);
      if (Run === 1'b1) rcnt++;
      else rcnt = 0;
      Done = stray_done || ((Run === 1'b1) && (rcnt == proc_lat(instruction)));
    end
  end

  // Per-cycle comparison against the model.
  always begin
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) ce = exp_q.pop_front();
    else ce = idle_v;
    ca.instr  = instruction;
    ca.run    = Run;
    ca.busy   = busy;
    ca.pc     = pc;
    ca.cnt    = issued_cnt;
    ca.fin    = finished;
    ca.halted = halted;
    ca.terr   = timeout_err;
    vectors++;
    if (ca !== ce) begin
      miscompares++;
      $display("FAIL cycle t=%0t got instr=%h run=%b busy=%b pc=%0d cnt=%0d fin=%b halt=%b to=%b expected instr=%h run=%b busy=%b pc=%0d cnt=%0d fin=%b halt=%b to=%b",
               $time, ca.instr, ca.run, ca.busy, ca.pc, ca.cnt, ca.fin, ca.halted, ca.terr,
               ce.instr, ce.run, ce.busy, ce.pc, ce.cnt, ce.fin, ce.halted, ce.terr);
    end
    cur_busy = ce.busy;
    if (Run === 1'b1) run_hi++;
    if (finished === 1'b1) fin_cnt++;
    if (Run === 1'b1 && instruction[15:13] == 3'b111) halt_issued = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [15:0] data);
    @(negedge clock);
    prog_we   = 1'b1;
    prog_addr = AW'(addr);
    prog_data = data;
    if (!cur_busy) mem_m[addr] = data;
    @(negedge clock);
    prog_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge clock);
    while ((cur_busy || exp_q.size() > 0) && k < 2000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 2000) begin
      miscompares++;
      $display("FAIL %s idle wait expired", name);
    end
  endtask

  task automatic wait_exec(input string name, input int p);
    int k;
    k = 0;
    while (!(Run === 1'b1 && pc == AW'(p)) && k < 500) begin
      @(negedge clock);
      k++;
    end
    if (k >= 500) begin
      miscompares++;
      $display("FAIL %s exec wait expired", name);
    end
  endtask

  // Launch a run; optionally write the store in the same cycle.
  task automatic start_run(input int n, input bit we, input int addr, input logic [15:0] data);
    wait_idle("pre_start");
    start = 1'b1;
    len   = (AW+1)'(n);
    if (we) begin
      prog_we   = 1'b1;
      prog_addr = AW'(addr);
      prog_data = data;
      if (!cur_busy) mem_m[addr] = data;
    end
    build_run(n);
    @(negedge clock);
    start   = 1'b0;
    prog_we = 1'b0;
  endtask

  task automatic clr_counts();
    run_hi      = 0;
    fin_cnt     = 0;
    halt_issued = 1'b0;
  endtask

  initial begin
    Rest      = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    start     = 1'b0;
    len       = '0;
    repeat (2) @(negedge clock);
    Rest = 1'b0;

    // 1: three-word program, mv/mv/add latencies
    wr(0, 16'h1205);
    wr(1, 16'h0401);
    wr(2, 16'h4003);
    clr_counts();
    start_run(3, 1'b0, 0, 16'h0);
    wait_idle("t1");
    chk("t1_cnt", 32'(issued_cnt), 32'd3);
    chk("t1_pc", 32'(pc), 32'd2);
    chk("t1_halted", 32'(halted), 32'd0);
    chk("t1_terr", 32'(timeout_err), 32'd0);
    chk("t1_run_cycles", 32'(run_hi), 32'd8);
    chk("t1_fin_pulses", 32'(fin_cnt), 32'd1);
    chk("t1_instr", 32'(instruction), 32'h4003);

    // 2: HALT at word 1
    wr(1, 16'hE000);
    wr(3, 16'h0402);
    clr_counts();
    start_run(4, 1'b0, 0, 16'h0);
    wait_idle("t2");
    chk("t2_halted", 32'(halted), 32'd1);
    chk("t2_cnt", 32'(issued_cnt), 32'd1);
    chk("t2_pc", 32'(pc), 32'd1);
    chk("t2_fin_pulses", 32'(fin_cnt), 32'd1);
    chk("t2_halt_issued", 32'(halt_issued), 32'd0);
    chk("t2_run_cycles", 32'(run_hi), 32'd2);

    // 3: dead processor, then Done on the last allowed cycle, then one cycle too late
    wr(1, 16'h0401);
    lat_override = 99;
    clr_counts();
    start_run(3, 1'b0, 0, 16'h0);
    wait_idle("t3");
    chk("t3_run_cycles", 32'(run_hi), 32'd15);
    chk("t3_terr", 32'(timeout_err), 32'd1);
    chk("t3_cnt", 32'(issued_cnt), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_fin_pulses", 32'(fin_cnt), 32'd1);
    lat_override = 15;
    clr_counts();
    start_run(1, 1'b0, 0, 16'h0);
    wait_idle("t3b");
    chk("t3b_cnt", 32'(issued_cnt), 32'd1);
    chk("t3b_terr", 32'(timeout_err), 32'd0);
    chk("t3b_run_cycles", 32'(run_hi), 32'd15);
    lat_override = 16;
    clr_counts();
    start_run(1, 1'b0, 0, 16'h0);
    wait_idle("t3c");
    chk("t3c_cnt", 32'(issued_cnt), 32'd0);
    chk("t3c_terr", 32'(timeout_err), 32'd1);
    lat_override = 0;

    // 4: reset during EXEC of word 1, then rerun from the retained store
    start_run(3, 1'b0, 0, 16'h0);
    wait_exec("t4", 1);
    Rest = 1'b1;
    exp_q.delete();
    idle_v = '0;
    @(posedge clock);
    #2;
    chk("t4_run", 32'(Run), 32'd0);
    chk("t4_pc", 32'(pc), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    @(negedge clock);
    Rest = 1'b0;
    start_run(3, 1'b0, 0, 16'h0);
    wait_idle("t4b");
    chk("t4_rerun_cnt", 32'(issued_cnt), 32'd3);
    chk("t4_rerun_instr", 32'(instruction), 32'h4003);

    // 5: out-of-range lengths; stray Done while idle must be ignored
    clr_counts();
    stray_done = 1'b1;
    start_run(0, 1'b0, 0, 16'h0);
    wait_idle("t5a");
    start_run(33, 1'b0, 0, 16'h0);
    wait_idle("t5b");
    stray_done = 1'b0;
    chk("t5_fin_pulses", 32'(fin_cnt), 32'd2);
    chk("t5_run_cycles", 32'(run_hi), 32'd0);
    chk("t5_cnt", 32'(issued_cnt), 32'd0);

    // 6: write attempted during EXEC is dropped
    start_run(3, 1'b0, 0, 16'h0);
    wait_exec("t6", 0);
    wr(2, 16'h0BAD);
    wait_idle("t6");
    chk("t6_instr", 32'(instruction), 32'h4003);
    chk("t6_cnt", 32'(issued_cnt), 32'd3);

    // 7: full-depth run, last word written in the same cycle as start
    for (int i = 0; i < DEPTH; i++) begin
      wr(i, (i % 2 == 1) ? (16'h4000 | 16'(i)) : (16'h0200 | 16'(i)));
    end
    clr_counts();
    start_run(DEPTH, 1'b1, 31, 16'h0C31);
    wait_idle("t7");
    chk("t7_cnt", 32'(issued_cnt), 32'd32);
    chk("t7_pc", 32'(pc), 32'd31);
    chk("t7_instr", 32'(instruction), 32'h0C31);
    chk("t7_fin_pulses", 32'(fin_cnt), 32'd1);

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "time limit");
  end

endmodule
